// File: rtl/rom_lector_pkg.sv
// Shared defaults and FSM state encoding for the rom_lector burst reader.
package rom_lector_pkg;

    localparam int ANCHO_DATO_DEF = 32;
    localparam int ANCHO_DIR_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEER    = 2'd1,
        ENTREGA = 2'd2,
        FIN     = 2'd3
    } estado_t;

endpackage

// File: rtl/rom_lector.sv
// Burst reader: walks a combinational ROM from base_i for cuenta_i+1 words, one word per valid/ready handshake.
// Optional XOR checksum output suma_o is built only when ROM_LECTOR_CHECKSUM_EN is defined.
module rom_lector
    import rom_lector_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inicio_i,
    input  logic [ANCHO_DIR-1:0]  base_i,
    input  logic [ANCHO_DIR-1:0]  cuenta_i,
    output logic [ANCHO_DIR-1:0]  dir_o,
    input  logic [ANCHO_DATO-1:0] dato_i,
    output logic [ANCHO_DATO-1:0] dato_o,
    output logic                  valido_o,
    input  logic                  listo_i,
    output logic                  ocupado_o,
    output logic                  hecho_o
`ifdef ROM_LECTOR_CHECKSUM_EN
    ,
    output logic [ANCHO_DATO-1:0] suma_o
`endif
);

    estado_t               estado_q, estado_d;
    logic [ANCHO_DIR-1:0]  dir_q, dir_d;
    logic [ANCHO_DIR-1:0]  rest_q, rest_d;
    logic [ANCHO_DATO-1:0] dato_q, dato_d;
    logic                  transfer;

    assign transfer = (estado_q == ENTREGA) && listo_i;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        estado_d = estado_q;
        dir_d    = dir_q;
        rest_d   = rest_q;
        dato_d   = dato_q;
        unique case (estado_q)
            IDLE: begin
                if (inicio_i) begin
                    dir_d    = base_i;
                    rest_d   = cuenta_i;
                    estado_d = LEER;
                end
            end
            LEER: begin
                dato_d   = dato_i;
                estado_d = ENTREGA;
            end
            ENTREGA: begin
                if (transfer) begin
                    if (rest_q == '0) begin
                        estado_d = FIN;
                    end else begin
                        // Address wraps naturally at the top of the ROM.
                        dir_d    = dir_q + ANCHO_DIR'(1);
                        rest_d   = rest_q - ANCHO_DIR'(1);
                        estado_d = LEER;
                    end
                end
            end
            FIN:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            estado_q <= IDLE;
            dir_q    <= '0;
            rest_q   <= '0;
            dato_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
            estado_q <= estado_d;
            dir_q    <= dir_d;
            rest_q   <= rest_d;
            dato_q   <= dato_d;
        end
    end

`ifdef ROM_LECTOR_CHECKSUM_EN
    logic [ANCHO_DATO-1:0] suma_q, suma_d;

    always_comb begin
        suma_d = suma_q;
        if ((estado_q == IDLE) && inicio_i) begin
            suma_d = '0;
        end else if (transfer) begin
            suma_d = suma_q ^ dato_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            suma_q <= '0;
        end else begin
            suma_q <= suma_d;
        end
    end

    assign suma_o = suma_q;
`endif

    // All outputs decode directly from registers, so reset clears them without waiting for a clock.
    assign dir_o     = dir_q;
    assign dato_o    = dato_q;
    assign valido_o  = (estado_q == ENTREGA);
    assign ocupado_o = (estado_q != IDLE);
    assign hecho_o   = (estado_q == FIN);

endmodule

// File: tb/tb_rom_lector.sv
// Self-checking bench for rom_lector: a ROM table drives dato_i, a cycle-count model predicts every output.
module tb_rom_lector;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        inicio_i;
    logic [3:0]  base_i;
    logic [3:0]  cuenta_i;
    logic [3:0]  dir_o;
    logic [31:0] dato_i;
    logic [31:0] dato_o;
    logic        valido_o;
    logic        listo_i;
    logic        ocupado_o;
    logic        hecho_o;
`ifdef ROM_LECTOR_CHECKSUM_EN
    logic [31:0] suma_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom_word(input logic [3:0] a);
        case (a)
            4'h0:    return 32'h0000_0001;
            4'h1:    return 32'h0000_0002;
            4'h2:    return 32'h0000_0003;
            4'h3:    return 32'hFEDC_BA98;
            4'h4:    return 32'h0BAD_F00D;
            4'h5:    return 32'h1234_5678;
            4'h6:    return 32'hA5A5_A5A5;
            4'h7:    return 32'h3999_2AAF;
            4'hF:    return 32'hFFFF_FFFF;
            default: return 32'hC0DE_0000 | 32'(a);
        endcase
    endfunction

    assign dato_i = rom_word(dir_o);

    rom_lector #(.ANCHO_DATO(32), .ANCHO_DIR(4)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inicio_i  (inicio_i),
        .base_i    (base_i),
        .cuenta_i  (cuenta_i),
        .dir_o     (dir_o),
        .dato_i    (dato_i),
        .dato_o    (dato_o),
        .valido_o  (valido_o),
        .listo_i   (listo_i),
        .ocupado_o (ocupado_o),
        .hecho_o   (hecho_o)
`ifdef ROM_LECTOR_CHECKSUM_EN
        ,
        .suma_o    (suma_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is a queue of addresses; each word is offered from cycle m_valid_from until accepted.
    logic [3:0]  m_q[$];
    bit          m_busy       = 1'b0;
    int          m_cyc        = 0;
    int          m_valid_from = 0;
    int          m_hecho_at   = -1;
    logic [3:0]  m_dir        = '0;
    logic [31:0] m_dato       = '0;
    logic [31:0] m_sum        = '0;

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                m_q.delete();
                m_busy     = 1'b0;
                m_hecho_at = -1;
                m_dir      = '0;
                m_dato     = '0;
                m_sum      = '0;
            end else begin
                int prev;
                prev = m_cyc;
                m_cyc++;
                if (m_busy) begin
                    if (m_q.size() > 0 && prev == m_valid_from - 1) begin
                        m_dato = rom_word(m_dir);
                    end else if (m_q.size() > 0 && prev >= m_valid_from && listo_i) begin
                        m_sum = m_sum ^ m_dato;
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) begin
                            m_hecho_at = m_cyc;
                        end else begin
                            m_dir        = m_q[0];
                            m_valid_from = m_cyc + 1;
                        end
                    end else if (m_q.size() == 0 && prev == m_hecho_at) begin
                        m_busy = 1'b0;
                    end
                end else if (inicio_i) begin
                    for (int i = 0; i <= int'(cuenta_i); i++) begin
                        logic [3:0] a;
                        a = base_i + 4'(i);
                        m_q.push_back(a);
                    end
                    m_busy       = 1'b1;
                    m_dir        = base_i;
                    m_valid_from = m_cyc + 1;
                    m_sum        = '0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            begin
                bit exp_valid, exp_hecho;
                exp_valid = m_busy && (m_q.size() > 0) && (m_cyc >= m_valid_from);
                exp_hecho = m_busy && (m_q.size() == 0) && (m_cyc == m_hecho_at);
                check("cyc_ocupado", 32'(ocupado_o), 32'(m_busy));
                check("cyc_valido",  32'(valido_o),  32'(exp_valid));
                check("cyc_hecho",   32'(hecho_o),   32'(exp_hecho));
                check("cyc_dir",     32'(dir_o),     32'(m_dir));
                check("cyc_dato",    dato_o,         m_dato);
`ifdef ROM_LECTOR_CHECKSUM_EN
                check("cyc_suma",    suma_o,         m_sum);
`endif
            end
        end
    end

    // Transfer log used by the directed literal checks.
    logic [31:0] got_dato[$];
    logic [3:0]  got_dir[$];
    int          hecho_cnt = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (valido_o && listo_i) begin
                got_dato.push_back(dato_o);
                got_dir.push_back(dir_o);
            end
            if (hecho_o) hecho_cnt++;
        end
    end

    task automatic start_burst(input logic [3:0] b, input logic [3:0] c);
        @(posedge clk_i); #1;
        base_i   = b;
        cuenta_i = c;
        inicio_i = 1'b1;
        @(posedge clk_i); #1;
        inicio_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i); #1;
            if (!ocupado_o) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i);
            if (valido_o) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_valid_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic clear_log();
        got_dato.delete();
        got_dir.delete();
    endtask

    initial begin
        int h0;
        rst_ni   = 1'b0;
        inicio_i = 1'b0;
        base_i   = '0;
        cuenta_i = '0;
        listo_i  = 1'b0;

        // Reset state.
        @(negedge clk_i);
        check("rst_ocupado", 32'(ocupado_o), 32'd0);
        check("rst_valido",  32'(valido_o),  32'd0);
        check("rst_hecho",   32'(hecho_o),   32'd0);
        check("rst_dir",     32'(dir_o),     32'd0);
        check("rst_dato",    dato_o,         32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Three-word burst from 0 with listo held high, plus first-word latency.
        listo_i = 1'b1;
        clear_log();
        h0 = hecho_cnt;
        start_burst(4'h0, 4'h2);
        @(negedge clk_i);
        check("lat_leer_valido",  32'(valido_o),  32'd0);
        check("lat_leer_ocupado", 32'(ocupado_o), 32'd1);
        @(negedge clk_i);
        check("lat_first_valido", 32'(valido_o), 32'd1);
        check("lat_first_dato",   dato_o,        32'h0000_0001);
        wait_idle("b0", 50);
        check("b0_count", 32'(got_dato.size()), 32'd3);
        if (got_dato.size() == 3) begin
            check("b0_w0", got_dato[0], 32'h0000_0001);
            check("b0_w1", got_dato[1], 32'h0000_0002);
            check("b0_w2", got_dato[2], 32'h0000_0003);
        end
        check("b0_hecho_once", 32'(hecho_cnt - h0), 32'd1);
`ifdef ROM_LECTOR_CHECKSUM_EN
        check("b0_suma", suma_o, 32'h0000_0000);
`endif

        // Wrap from address F to 0.
        clear_log();
        start_burst(4'hF, 4'h1);
        wait_idle("wrap", 50);
        check("wrap_count", 32'(got_dato.size()), 32'd2);
        if (got_dato.size() == 2) begin
            check("wrap_dir0", 32'(got_dir[0]), 32'hF);
            check("wrap_dir1", 32'(got_dir[1]), 32'h0);
            check("wrap_w0",   got_dato[0],     32'hFFFF_FFFF);
            check("wrap_w1",   got_dato[1],     32'h0000_0001);
        end
`ifdef ROM_LECTOR_CHECKSUM_EN
        check("wrap_suma", suma_o, 32'hFFFF_FFFE);
`endif

        // Back-pressure: single word held while listo_i is low.
        listo_i = 1'b0;
        clear_log();
        start_burst(4'h3, 4'h0);
        wait_valid("bp", 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_hold_valido", 32'(valido_o), 32'd1);
            check("bp_hold_dato",   dato_o,        32'hFEDC_BA98);
        end
        @(posedge clk_i); #1 listo_i = 1'b1;
        @(negedge clk_i);
        check("bp_xfer_valido", 32'(valido_o), 32'd1);
        @(negedge clk_i);
        check("bp_hecho",       32'(hecho_o),  32'd1);
        check("bp_after_valid", 32'(valido_o), 32'd0);
        @(negedge clk_i);
        check("bp_hecho_end",   32'(hecho_o),   32'd0);
        check("bp_idle",        32'(ocupado_o), 32'd0);
        check("bp_count", 32'(got_dato.size()), 32'd1);

        // Restart attempt mid-burst is ignored.
        clear_log();
        start_burst(4'h0, 4'hF);
        repeat (5) @(posedge clk_i);
        #1;
        base_i   = 4'h5;
        cuenta_i = 4'h3;
        inicio_i = 1'b1;
        @(posedge clk_i); #1 inicio_i = 1'b0;
        wait_idle("full", 100);
        check("full_count", 32'(got_dato.size()), 32'd16);
        if (got_dato.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("full_dir",  32'(got_dir[i]), 32'(i));
                check("full_dato", got_dato[i],     rom_word(4'(i)));
            end
        end

        // Reset during ENTREGA abandons the burst.
        listo_i = 1'b0;
        start_burst(4'h4, 4'h2);
        wait_valid("rstb", 20);
        h0 = hecho_cnt;
        #2 rst_ni = 1'b0;
        #1;
        check("rstb_ocupado", 32'(ocupado_o), 32'd0);
        check("rstb_valido",  32'(valido_o),  32'd0);
        check("rstb_hecho",   32'(hecho_o),   32'd0);
        check("rstb_dir",     32'(dir_o),     32'd0);
        check("rstb_dato",    dato_o,         32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        listo_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rstb_no_hecho", 32'(hecho_cnt), 32'(h0));
        clear_log();
        start_burst(4'h7, 4'h0);
        wait_idle("rstb_new", 20);
        check("rstb_new_count", 32'(got_dato.size()), 32'd1);
        if (got_dato.size() == 1) check("rstb_new_word", got_dato[0], 32'h3999_2AAF);

        // Randomized bursts with random back-pressure, stray starts and occasional reset.
        for (int b = 0; b < 60; b++) begin
            bit done;
            start_burst(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & (($urandom % 2) ? 15 : 3)));
            done = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk_i); #1;
                listo_i  = ($urandom % 3) != 0;
                inicio_i = ($urandom % 10) == 0;
                base_i   = 4'($urandom);
                cuenta_i = 4'($urandom);
                if (($urandom % 150) == 0) begin
                    rst_ni = 1'b0;
                    @(posedge clk_i); #1 rst_ni = 1'b1;
                end
                @(negedge clk_i);
                if (!ocupado_o) begin
                    done = 1'b1;
                    break;
                end
            end
            inicio_i = 1'b0;
            check("rnd_burst_timeout", 32'(done), 32'd1);
        end
        listo_i = 1'b1;
        wait_idle("rnd_end", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
